// File: rtl/seven_segment_decoder_pkg.sv
// Shared glyph and mode definitions for the 7-segment encoder/decoder pair.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package seven_segment_decoder_pkg;

   // Segment word layout is {a,b,c,d,e,f,g}, a in bit 6.
   localparam logic [6:0] SEG_0     = 7'h7e;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6d;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5b;
   localparam logic [6:0] SEG_6     = 7'h5f;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7f;
   localparam logic [6:0] SEG_9     = 7'h7b;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h1f;
   localparam logic [6:0] SEG_C     = 7'h4e;
   localparam logic [6:0] SEG_D     = 7'h3d;
   localparam logic [6:0] SEG_E     = 7'h4f;
   localparam logic [6:0] SEG_F     = 7'h47;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Mode codes; 2'b1x decodes like hex.
   localparam logic [1:0] MODE_HEX  = 2'b00;
   localparam logic [1:0] MODE_DEC  = 2'b01;

   // Decoded result of one segment word.
   typedef struct packed {
      logic [3:0] num;
      logic       blank;
      logic       error;
   } seg_dec_t;

endpackage

// File: rtl/seven_segment_pattern_lut.sv
// Maps a {segment word, mode} pair to {value, blank, error}; flags mutually exclusive.
// Latency: purely combinational.
// Backpressure: none.
module seven_segment_pattern_lut
   import seven_segment_decoder_pkg::*;
(
   input  logic [6:0] word,
   input  logic [1:0] mode,
   output seg_dec_t   dec
);

   logic dec_only;
   assign dec_only = (mode == MODE_DEC);

   // Table lookup; letters become errors in decimal-only mode.
   always_comb begin
      dec = '0;
      case (word)
         SEG_0:     dec.num = 4'h0;
         SEG_1:     dec.num = 4'h1;
         SEG_2:     dec.num = 4'h2;
         SEG_3:     dec.num = 4'h3;
         SEG_4:     dec.num = 4'h4;
         SEG_5:     dec.num = 4'h5;
         SEG_6:     dec.num = 4'h6;
         SEG_7:     dec.num = 4'h7;
         SEG_8:     dec.num = 4'h8;
         SEG_9:     dec.num = 4'h9;
         SEG_A:     if (dec_only) dec.error = 1'b1; else dec.num = 4'hA;
         SEG_B:     if (dec_only) dec.error = 1'b1; else dec.num = 4'hB;
         SEG_C:     if (dec_only) dec.error = 1'b1; else dec.num = 4'hC;
         SEG_D:     if (dec_only) dec.error = 1'b1; else dec.num = 4'hD;
         SEG_E:     if (dec_only) dec.error = 1'b1; else dec.num = 4'hE;
         SEG_F:     if (dec_only) dec.error = 1'b1; else dec.num = 4'hF;
         SEG_BLANK: dec.blank = 1'b1;
         default:   dec.error = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_segment_decoder.sv
// Recovers the 4-bit value from sampled 7-segment lines after a 2-flop sync and a stability window.
// Latency: word change sampled on edge N -> o_valid pulse after edge N+2+STABLE_CYCLES (i_mode change: one edge after the change + STABLE_CYCLES).
// Backpressure: none; one o_valid pulse per accepted pattern, outputs hold until the next pulse.
// Build option ACTIVE_LOW_SEG_EN: segment inputs are active-low and are inverted after the synchroniser.
module seven_segment_decoder
   import seven_segment_decoder_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,   // >= 1
   parameter int CNT_W         = 8    // 2**CNT_W > STABLE_CYCLES
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_mode,
   input  logic       i_segment_a,
   input  logic       i_segment_b,
   input  logic       i_segment_c,
   input  logic       i_segment_d,
   input  logic       i_segment_e,
   input  logic       i_segment_f,
   input  logic       i_segment_g,
   output logic [3:0] o_binary_num,
   output logic       o_valid,
   output logic       o_blank,
   output logic       o_error
);

   localparam logic [0:0] ST_SETTLING = 1'b0;
   localparam logic [0:0] ST_STABLE   = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [6:0]       seg_raw;
   logic [6:0]       sync_q1;
   logic [6:0]       sync_q2;
   logic [6:0]       prev_word;
   logic [1:0]       prev_mode;
   logic [6:0]       word;
   logic             changed;
   logic [CNT_W-1:0] count;
   logic [0:0]       state;
   seg_dec_t         dec;

   assign seg_raw = {i_segment_a, i_segment_b, i_segment_c, i_segment_d,
                     i_segment_e, i_segment_f, i_segment_g};

`ifdef ACTIVE_LOW_SEG_EN
   assign word = ~sync_q2;
`else
   assign word = sync_q2;
`endif

   // Change detection works on the raw synchronised word; polarity does not matter for it.
   assign changed = (sync_q2 != prev_word) || (i_mode != prev_mode);

   // Two-flop synchroniser plus one-cycle history for change detection.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q1   <= '0;
         sync_q2   <= '0;
         prev_word <= '0;
         prev_mode <= '0;
      end else begin
         sync_q1   <= seg_raw;
         sync_q2   <= sync_q1;
         prev_word <= sync_q2;
         prev_mode <= i_mode;
      end
   end

   seven_segment_pattern_lut u_lut (
      .word (word),
      .mode (i_mode),
      .dec  (dec)
   );

   // Stability FSM; results latch only on the pulse edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= ST_SETTLING;
         count        <= '0;
         o_valid      <= 1'b0;
         o_binary_num <= 4'h0;
         o_blank      <= 1'b0;
         o_error      <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (changed) begin
            state <= ST_SETTLING;
            count <= '0;
         end else if (state == ST_SETTLING) begin
            if (count == CNT_LAST) begin
               state        <= ST_STABLE;
               o_valid      <= 1'b1;
               o_binary_num <= dec.num;
               o_blank      <= dec.blank;
               o_error      <= dec.error;
            end
            count <= count + 1'b1;
         end else if (count != '1) begin
            // Saturate while parked in STABLE so a long hold never wraps.
            count <= count + 1'b1;
         end
      end
   end

endmodule
